// File: rtl/pg_rca_pkg.sv
// pg_rca_pkg -- shared definitions for the pipelined propagate/generate
// ripple-carry adder.
//   PG_UNSIGNED / PG_SIGNED : values of the SIGNED parameter of pg_rca_pipe
//   stage_count(width, seg) : number of pipeline stages, ceil(width/seg)
//   seg_bits(k, width, seg) : bits resolved by stage k (last one may be short)
package pg_rca_pkg;

    localparam int PG_UNSIGNED = 0;
    localparam int PG_SIGNED   = 1;

    function automatic int stage_count(input int width, input int seg);
        return (width + seg - 1) / seg;
    endfunction

    function automatic int seg_bits(input int k, input int width, input int seg);
        int rem;
        rem = width - k * seg;
        return (rem < seg) ? rem : seg;
    endfunction

endpackage

// File: rtl/pg_rca_seg.sv
// pg_rca_seg -- combinational N-bit propagate/generate ripple segment.
//   a, b     : operand slices
//   cin      : carry into bit 0 of the slice
//   sum      : slice sum
//   cout     : carry out of the top bit
//   c_msb_in : carry into the top bit (used for signed overflow detection)
module pg_rca_seg #(
    parameter int N = 4
) (
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         cin,
    output logic [N-1:0] sum,
    output logic         cout,
    output logic         c_msb_in
);

    logic [N-1:0] p_s;
    logic [N-1:0] g_s;
    logic [N:0]   c_s;

    assign p_s = a ^ b;
    assign g_s = a & b;

    // Carry ripple: c[i+1] = g[i] | (p[i] & c[i])
    always_comb begin
        c_s[0] = cin;
        for (int i = 0; i < N; i++) begin
            c_s[i+1] = g_s[i] | (p_s[i] & c_s[i]);
        end
    end

    assign sum      = p_s ^ c_s[N-1:0];
    assign cout     = c_s[N];
    assign c_msb_in = c_s[N-1];

endmodule

// File: rtl/pg_rca_pipe.sv
// pg_rca_pipe -- pipelined PG ripple-carry adder, one SEG-bit segment per stage.
//   clk, rst             : clock, synchronous active-high reset
//   in_valid / in_ready  : input handshake (in_ready is combinational)
//   in_a, in_b, in_cin   : operands and carry-in
//   out_valid / out_ready: output handshake
//   out_sum              : WIDTH+1-bit sum; top bit is carry-out (unsigned) or
//                          the sign-extension bit (signed)
//   out_ovf              : c_W (unsigned) or c_W ^ c_(W-1) (signed)
// Each stage loads from its predecessor when it is empty or its own contents
// move on, so bubbles collapse without a global stall. The last stage register
// is the output register.
module pg_rca_pipe
    import pg_rca_pkg::*;
#(
    parameter int WIDTH  = 8,
    parameter int SEG    = 4,
    parameter int SIGNED = PG_UNSIGNED
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH:0]   out_sum,
    output logic             out_ovf
);

    localparam int STAGES = stage_count(WIDTH, SEG);

    // Stage state: operands travel with the partial sum until their segment
    // has been resolved; carry_r is the carry into the next segment.
    logic [STAGES-1:0] valid_r;
    logic [STAGES-1:0] carry_r;
    logic [WIDTH-1:0]  a_r   [STAGES];
    logic [WIDTH-1:0]  b_r   [STAGES];
    logic [WIDTH-1:0]  sum_r [STAGES];
    logic              top_r;
    logic              ovf_r;

    // go_s[k]: stage k loads this cycle; go_s[STAGES] is the output acceptance
    logic [STAGES:0]   go_s;
    logic [STAGES-1:0] nxt_v_s;
    logic [STAGES-1:0] nxt_c_s;
    logic [WIDTH-1:0]  nxt_a_s [STAGES];
    logic [WIDTH-1:0]  nxt_b_s [STAGES];
    logic [WIDTH-1:0]  nxt_s_s [STAGES];
    logic              top_nxt_s;
    logic              ovf_nxt_s;

    // Load enables ripple back from the output so a full pipe can accept and
    // emit in the same cycle.
    always_comb begin
        go_s[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            go_s[k] = !valid_r[k] || go_s[k+1];
        end
    end

    assign in_ready = go_s[0];

    for (genvar k = 0; k < STAGES; k++) begin : g_st
        localparam int LO = k * SEG;
        localparam int NB = seg_bits(k, WIDTH, SEG);

        logic [WIDTH-1:0] src_a_s;
        logic [WIDTH-1:0] src_b_s;
        logic [WIDTH-1:0] src_s_s;
        logic             src_c_s;
        logic [NB-1:0]    seg_sum_s;
        logic             seg_cout_s;
        logic             seg_cmsb_s;
        logic [WIDTH-1:0] splice_s;

        if (k == 0) begin : g_src
            assign nxt_v_s[k] = in_valid;
            assign src_a_s    = in_a;
            assign src_b_s    = in_b;
            assign src_s_s    = {WIDTH{1'b0}};
            assign src_c_s    = in_cin;
        end else begin : g_src
            assign nxt_v_s[k] = valid_r[k-1];
            assign src_a_s    = a_r[k-1];
            assign src_b_s    = b_r[k-1];
            assign src_s_s    = sum_r[k-1];
            assign src_c_s    = carry_r[k-1];
        end

        pg_rca_seg #(.N(NB)) u_seg (
            .a        (src_a_s[LO +: NB]),
            .b        (src_b_s[LO +: NB]),
            .cin      (src_c_s),
            .sum      (seg_sum_s),
            .cout     (seg_cout_s),
            .c_msb_in (seg_cmsb_s)
        );

        // Drop this segment's freshly resolved bits into the running sum
        always_comb begin
            splice_s            = src_s_s;
            splice_s[LO +: NB]  = seg_sum_s;
        end

        assign nxt_a_s[k] = src_a_s;
        assign nxt_b_s[k] = src_b_s;
        assign nxt_s_s[k] = splice_s;
        assign nxt_c_s[k] = seg_cout_s;

        // The last stage owns bit W-1, so c_W and c_(W-1) are both local here
        if (k == STAGES - 1) begin : g_last
            assign top_nxt_s = (SIGNED == PG_SIGNED)
                             ? (src_a_s[WIDTH-1] ^ src_b_s[WIDTH-1] ^ seg_cout_s)
                             : seg_cout_s;
            assign ovf_nxt_s = (SIGNED == PG_SIGNED)
                             ? (seg_cout_s ^ seg_cmsb_s)
                             : seg_cout_s;
        end else begin : g_mid
            logic unused_cmsb_s;
            assign unused_cmsb_s = seg_cmsb_s;
        end
    end

    // Stage registers: the valid bit follows every load, data only loads with
    // a real beat so the output holds its last result across bubbles.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= {STAGES{1'b0}};
            carry_r <= {STAGES{1'b0}};
            top_r   <= 1'b0;
            ovf_r   <= 1'b0;
            for (int k = 0; k < STAGES; k++) begin
                a_r[k]   <= {WIDTH{1'b0}};
                b_r[k]   <= {WIDTH{1'b0}};
                sum_r[k] <= {WIDTH{1'b0}};
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (go_s[k]) begin
                    valid_r[k] <= nxt_v_s[k];
                    if (nxt_v_s[k]) begin
                        a_r[k]     <= nxt_a_s[k];
                        b_r[k]     <= nxt_b_s[k];
                        sum_r[k]   <= nxt_s_s[k];
                        carry_r[k] <= nxt_c_s[k];
                    end
                end
            end
            if (go_s[STAGES-1] && nxt_v_s[STAGES-1]) begin
                top_r <= top_nxt_s;
                ovf_r <= ovf_nxt_s;
            end
        end
    end

    // Operands and carry held in the last stage have no consumer
    logic unused_s;
    assign unused_s = ^{a_r[STAGES-1], b_r[STAGES-1], carry_r[STAGES-1]};

    assign out_valid = valid_r[STAGES-1];
    assign out_sum   = {top_r, sum_r[STAGES-1]};
    assign out_ovf   = ovf_r;

endmodule

// File: tb/tb_pg_rca_pipe.sv
// tb_pg_rca_pipe -- directed and random checks of pg_rca_pipe across five
// configurations, with a per-instance scoreboard of expected {ovf, sum}.
module tb_pg_rca_pipe;

    localparam int ND = 5;
    localparam int WD [ND] = '{8, 8, 7, 16, 33};
    localparam int SG [ND] = '{0, 1, 0, 1, 0};
    localparam int ST [ND] = '{2, 2, 3, 16, 9};

    logic clk = 1'b0;
    logic rst;
    logic [ND-1:0] iv;
    logic [ND-1:0] ic;
    logic [ND-1:0] ordy;
    logic [63:0]   ia [ND];
    logic [63:0]   ib [ND];
    wire  [ND-1:0] irdy;
    wire  [ND-1:0] ov;
    wire  [ND-1:0] oovf;
    wire  [8:0]    sum0;
    wire  [8:0]    sum1;
    wire  [7:0]    sum2;
    wire  [16:0]   sum3;
    wire  [33:0]   sum4;
    wire  [64:0]   osum [ND];

    logic [65:0] q [ND][$];
    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    assign osum[0] = {56'd0, sum0};
    assign osum[1] = {56'd0, sum1};
    assign osum[2] = {57'd0, sum2};
    assign osum[3] = {48'd0, sum3};
    assign osum[4] = {31'd0, sum4};

    pg_rca_pipe #(.WIDTH(8), .SEG(4), .SIGNED(0)) u_d0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
        .in_a(ia[0][7:0]), .in_b(ib[0][7:0]), .in_cin(ic[0]),
        .out_valid(ov[0]), .out_ready(ordy[0]), .out_sum(sum0), .out_ovf(oovf[0]));
    pg_rca_pipe #(.WIDTH(8), .SEG(4), .SIGNED(1)) u_d1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
        .in_a(ia[1][7:0]), .in_b(ib[1][7:0]), .in_cin(ic[1]),
        .out_valid(ov[1]), .out_ready(ordy[1]), .out_sum(sum1), .out_ovf(oovf[1]));
    pg_rca_pipe #(.WIDTH(7), .SEG(3), .SIGNED(0)) u_d2 (
        .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
        .in_a(ia[2][6:0]), .in_b(ib[2][6:0]), .in_cin(ic[2]),
        .out_valid(ov[2]), .out_ready(ordy[2]), .out_sum(sum2), .out_ovf(oovf[2]));
    pg_rca_pipe #(.WIDTH(16), .SEG(1), .SIGNED(1)) u_d3 (
        .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
        .in_a(ia[3][15:0]), .in_b(ib[3][15:0]), .in_cin(ic[3]),
        .out_valid(ov[3]), .out_ready(ordy[3]), .out_sum(sum3), .out_ovf(oovf[3]));
    pg_rca_pipe #(.WIDTH(33), .SEG(4), .SIGNED(0)) u_d4 (
        .clk(clk), .rst(rst), .in_valid(iv[4]), .in_ready(irdy[4]),
        .in_a(ia[4][32:0]), .in_b(ib[4][32:0]), .in_cin(ic[4]),
        .out_valid(ov[4]), .out_ready(ordy[4]), .out_sum(sum4), .out_ovf(oovf[4]));

    // Reference: exact (W+1)-bit sum of the zero- or sign-extended operands
    function automatic logic [65:0] model(input int d, input logic [63:0] a,
                                          input logic [63:0] b, input logic c);
        int w;
        logic [65:0] m, ea, eb, s;
        logic ovf;
        w  = WD[d];
        m  = (66'd1 << w) - 66'd1;
        ea = {2'b00, a} & m;
        eb = {2'b00, b} & m;
        if (SG[d] == 1 && a[w-1]) ea = ea | ~m;
        if (SG[d] == 1 && b[w-1]) eb = eb | ~m;
        s  = ea + eb + {65'd0, c};
        ovf = (SG[d] == 1) ? (s[w] ^ s[w-1]) : s[w];
        m  = (66'd1 << (w + 1)) - 66'd1;
        return {ovf, s[64:0] & m[64:0]};
    endfunction

    task automatic chk(input string tag, input logic [65:0] got, input logic [65:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // One clock cycle on instance d; entered and left 1 time unit after posedge.
    // A visible result is always checked against the scoreboard head, so a
    // stalled output must hold its value; it is popped only on a handshake.
    task automatic cyc(input int d, input logic v, input logic [63:0] a, input logic [63:0] b,
                       input logic c, input logic r, output logic acc, output logic rdy);
        iv[d] = v; ia[d] = a; ib[d] = b; ic[d] = c; ordy[d] = r;
        #1;
        rdy = irdy[d];
        acc = v && rdy;
        if (ov[d]) begin
            if (q[d].size() == 0) begin
                chk("spurious_out_valid", 66'(ov[d]), 66'd0);
            end else begin
                chk("scoreboard", {oovf[d], osum[d]}, q[d][0]);
                if (r) void'(q[d].pop_front());
            end
        end
        if (acc) q[d].push_back(model(d, a, b, c));
        @(posedge clk);
        #1;
    endtask

    task automatic drain(input int d);
        logic acc, rdy;
        for (int k = 0; k < 300 && q[d].size() != 0; k++) begin
            cyc(d, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc, rdy);
        end
        chk("drain_empty", 66'(q[d].size()), 66'd0);
    endtask

    // Single beat into an empty pipe: checks value, overflow and latency
    task automatic lat(input int d, input logic [63:0] a, input logic [63:0] b, input logic c,
                       input logic [64:0] es, input logic eo, input string tag);
        logic acc, rdy;
        int n;
        cyc(d, 1'b1, a, b, c, 1'b1, acc, rdy);
        chk({tag, "_accept"}, 66'(acc), 66'd1);
        iv[d] = 1'b0; ordy[d] = 1'b1;
        n = 0;
        for (int k = 1; k <= 40 && n == 0; k++) begin
            #1;
            if (ov[d]) n = k;
            else begin
                @(posedge clk);
                #1;
            end
        end
        chk({tag, "_latency"}, 66'(n), 66'(ST[d]));
        chk({tag, "_result"}, {oovf[d], osum[d]}, {eo, es});
        if (q[d].size() != 0) begin
            chk({tag, "_model"}, {oovf[d], osum[d]}, q[d][0]);
            void'(q[d].pop_front());
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        logic acc, rdy, v, r;
        int i;
        rst = 1'b1;
        iv = '0; ic = '0; ordy = '1;
        for (int d = 0; d < ND; d++) begin
            ia[d] = 64'd0;
            ib[d] = 64'd0;
        end
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        #1;
        for (int d = 0; d < ND; d++) begin
            chk("reset_out_valid", 66'(ov[d]), 66'd0);
            chk("reset_out_sum", 66'(osum[d]), 66'd0);
            chk("reset_out_ovf", 66'(oovf[d]), 66'd0);
            chk("reset_in_ready", 66'(irdy[d]), 66'd1);
        end
        @(posedge clk);
        #1;

        // Carry-out boundary and latency, unsigned 8/4
        lat(0, 64'hFF, 64'h01, 1'b0, 65'h100, 1'b1, "u8_ff_plus_1");
        // Signed 8/4
        lat(1, 64'h80, 64'hFF, 1'b0, 65'h17F, 1'b1, "s8_neg_ovf");
        lat(1, 64'h7F, 64'h01, 1'b0, 65'h080, 1'b1, "s8_pos_ovf");
        lat(1, 64'h05, 64'hFD, 1'b1, 65'h003, 1'b0, "s8_cin_no_ovf");
        // Uneven split: 7 bits in 3-bit segments, last segment one bit
        lat(2, 64'h7F, 64'h7F, 1'b1, 65'hFF, 1'b1, "u7_seg3");
        // One bit per stage, signed, most-negative plus most-negative
        lat(3, 64'h8000, 64'h8000, 1'b0, 65'h10000, 1'b1, "s16_seg1");
        // 33 bits, 4-bit segments
        lat(4, 64'h1_FFFF_FFFF, 64'h1, 1'b0, 65'h2_0000_0000, 1'b1, "u33_seg4");

        // Backpressure: six beats, out_ready low in cycles 3..6
        i = 0;
        for (int cy = 1; cy <= 40 && (i < 6 || q[0].size() != 0); cy++) begin
            r = !(cy >= 3 && cy <= 6);
            cyc(0, (i < 6), 64'(i), 64'(2 * i), 1'b0, r, acc, rdy);
            if (cy == 2) chk("bp_ready_before_stall", 66'(rdy), 66'd1);
            if (cy >= 3 && cy <= 6) chk("bp_ready_when_full", 66'(rdy), 66'd0);
            if (acc) i++;
        end
        chk("bp_all_accepted", 66'(i), 66'd6);
        chk("bp_all_emitted", 66'(q[0].size()), 66'd0);

        // Reset with two beats in flight and the output stalled
        cyc(0, 1'b1, 64'h11, 64'h22, 1'b0, 1'b1, acc, rdy);
        cyc(0, 1'b1, 64'h33, 64'h44, 1'b0, 1'b0, acc, rdy);
        rst = 1'b1;
        iv[0] = 1'b0;
        ordy[0] = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        q[0].delete();
        #1;
        chk("midrst_out_valid", 66'(ov[0]), 66'd0);
        chk("midrst_out_sum", 66'(osum[0]), 66'd0);
        chk("midrst_out_ovf", 66'(oovf[0]), 66'd0);
        chk("midrst_in_ready", 66'(irdy[0]), 66'd1);
        @(posedge clk);
        #1;
        for (int k = 0; k < 4; k++) begin
            cyc(0, 1'b0, 64'd0, 64'd0, 1'b0, 1'b1, acc, rdy);
            chk("midrst_no_stale_result", 66'(ov[0]), 66'd0);
        end
        lat(0, 64'd3, 64'd4, 1'b0, 65'd7, 1'b0, "after_reset");

        // Random traffic with random valid/ready on every configuration
        for (int d = 0; d < ND; d++) begin
            for (int n = 0; n < 2000; n++) begin
                v = ($urandom_range(0, 3) != 0);
                r = ($urandom_range(0, 3) != 0);
                cyc(d, v, {$urandom, $urandom}, {$urandom, $urandom},
                    1'($urandom_range(0, 1)), r, acc, rdy);
            end
            drain(d);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
